// File: rtl/rs_ctrl_pkg.sv
// Shared types and constants for the RS flag bank controller:
// the FSM state encoding, the operation codes and the default bank size.
package rs_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic OP_SET      = 1'b1;
    localparam logic OP_RST      = 1'b0;
    localparam int   N_FLAGS_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is one-hot. After each accepted
// grant, the registered pointer moves to the requester that did not win.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // A win by A hands priority to B (pointer 1), and a win by B hands it back to A.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (|o_grant)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/rs_flag_bank_ctrl.sv
// Controller for an external RS flag bank. It arbitrates between two requesters,
// drives one active-low strobe per operation and keeps a shadow copy of the bank.
module rs_flag_bank_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int N_FLAGS = N_FLAGS_DEF,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a,
    input  logic               op_a,
    input  logic [IDX_W-1:0]   idx_a,
    output logic               ack_a,
    input  logic               req_b,
    input  logic               op_b,
    input  logic [IDX_W-1:0]   idx_b,
    output logic               ack_b,
    output logic [N_FLAGS-1:0] s_n,
    output logic [N_FLAGS-1:0] r_n,
    output logic [N_FLAGS-1:0] q,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_op;
    logic [IDX_W-1:0]   r_idx;
    logic               r_win;
    logic [N_FLAGS-1:0] r_q;
    logic [1:0]         w_grant;
    logic               w_advance;
    logic [N_FLAGS-1:0] w_hit;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({req_b, req_a}),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_INIT:  w_state_next = ST_IDLE;
            ST_IDLE: begin
                if (|w_grant) begin
                    w_state_next = ST_DRIVE;
                    w_advance    = 1'b1;
                end
            end
            ST_DRIVE: w_state_next = ST_ACK;
            ST_ACK:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_op    <= OP_RST;
            r_idx   <= '0;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_win <= w_grant[1];
                r_op  <= w_grant[1] ? op_b : op_a;
                r_idx <= w_grant[1] ? idx_b : idx_a;
            end
        end
    end

    // An index outside the bank matches no bit, so it produces no strobe and leaves q unchanged.
    // Strobes are decoded from registered state and index only. The rst term holds
    // the bank in hold while reset is asserted.
    genvar gi;
    generate
        for (gi = 0; gi < N_FLAGS; gi++) begin : g_flag
            assign w_hit[gi] = (r_state == ST_DRIVE) && (r_idx == IDX_W'(gi));
            assign s_n[gi]   = ~(w_hit[gi] && (r_op == OP_SET) && !rst);
            assign r_n[gi]   = ~(((w_hit[gi] && (r_op == OP_RST)) || (r_state == ST_INIT)) && !rst);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q[gi] <= 1'b0;
                end else if (w_hit[gi]) begin
                    r_q[gi] <= r_op;
                end
            end
        end
    endgenerate

    assign q     = r_q;
    assign ack_a = (r_state == ST_ACK) && !r_win && !rst;
    assign ack_b = (r_state == ST_ACK) && r_win && !rst;
    assign busy  = (r_state != ST_IDLE) || rst;

endmodule
